// File: rtl/dcm_seq_pkg.sv
// dcm_seq_pkg: shared definitions for the DCM reset sequencer and the
// board-level LED/status decode that interprets seq_state.
package dcm_seq_pkg;

    localparam int NUM_CHAN   = 3;   // bit0 main, bit1 two, bit2 sram
    localparam int TIMER_W    = 16;
    localparam int LOSS_CNT_W = 8;

    // Encodings are fixed so that external decode logic can rely on them.
    localparam logic [1:0] SEQ_ENC_WAIT_LOCK = 2'd0;
    localparam logic [1:0] SEQ_ENC_DCM_RST   = 2'd1;
    localparam logic [1:0] SEQ_ENC_STABLE    = 2'd2;
    localparam logic [1:0] SEQ_ENC_RUN       = 2'd3;

    typedef enum logic [1:0] {
        WAIT_LOCK = SEQ_ENC_WAIT_LOCK,
        DCM_RST   = SEQ_ENC_DCM_RST,
        STABLE    = SEQ_ENC_STABLE,
        RUN       = SEQ_ENC_RUN
    } seq_state_e;

    // Saturating increment for the lock-loss event counter.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == {LOSS_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dcm_reset_sequencer_if.sv
// dcm_reset_sequencer_if: lock inputs and reset/status outputs of the
// sequencer. lock_loss_count exists only when DCM_LOCK_LOSS_COUNT_EN is defined.
// master = the sequencer, slave = the DCM/status side.
interface dcm_reset_sequencer_if;
    import dcm_seq_pkg::*;

    logic [NUM_CHAN-1:0] dcm_locked_in;
    logic [NUM_CHAN-1:0] dcm_reset_out;
    logic                sys_reset_n;
    logic                all_locked;
    logic [1:0]          seq_state;
`ifdef DCM_LOCK_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] lock_loss_count;

    modport master (
        input  dcm_locked_in,
        output dcm_reset_out, sys_reset_n, all_locked, seq_state, lock_loss_count
    );
    modport slave (
        output dcm_locked_in,
        input  dcm_reset_out, sys_reset_n, all_locked, seq_state, lock_loss_count
    );
`else
    modport master (
        input  dcm_locked_in,
        output dcm_reset_out, sys_reset_n, all_locked, seq_state
    );
    modport slave (
        output dcm_locked_in,
        input  dcm_reset_out, sys_reset_n, all_locked, seq_state
    );
`endif
endinterface

// File: rtl/dcm_reset_sequencer_lock_sync.sv
// lock_sync: two-flop synchronizer for one asynchronous DCM LOCKED flag,
// cleared asynchronously so the sequencer sees "unlocked" during reset.
module lock_sync (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/dcm_reset_sequencer.sv
// dcm_reset_sequencer: waits for the DCMs to lock, pulses DCM reset on
// channels that fail to lock in time, and releases the downstream system
// reset after a run of consecutive locked cycles.
// Optional lock-loss counter: define DCM_LOCK_LOSS_COUNT_EN.
module dcm_reset_sequencer
    import dcm_seq_pkg::*;
#(
    parameter int                  LOCK_TIMEOUT   = 50000,
    parameter int                  DCM_RST_CYCLES = 10,
    parameter int                  STABLE_CYCLES  = 1024,
    parameter logic [NUM_CHAN-1:0] CHAN_MASK      = 3'b111
) (
    input  logic                   input_clk,
    input  logic                   reset_n,
    dcm_reset_sequencer_if.master  bus
);
    // All timer compares are equalities against parameter-1, so the timer never wraps.
    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(DCM_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);

    logic [NUM_CHAN-1:0] lock_sync_w;
    logic                all_locked_d, all_locked_q;
    seq_state_e          state_d, state_q;
    logic [TIMER_W-1:0]  timer_d, timer_q;
    logic [NUM_CHAN-1:0] rst_out_d, rst_out_q;
    logic                sys_rst_n_d, sys_rst_n_q;
`ifdef DCM_LOCK_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_d, loss_cnt_q;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_sync
            lock_sync u_lock_sync (
                .clk   (input_clk),
                .clr_n (reset_n),
                .d     (bus.dcm_locked_in[gi]),
                .q     (lock_sync_w[gi])
            );
        end
    endgenerate

    // Unmonitored channels read as locked; an empty mask is always locked.
    assign all_locked_d = &(lock_sync_w | ~CHAN_MASK);

    // Next-state logic. The FSM acts on the same synchronized lock value that
    // is registered into all_locked, so state and all_locked change together.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rst_out_d = rst_out_q;
`ifdef DCM_LOCK_LOSS_COUNT_EN
        loss_cnt_d = loss_cnt_q;
`endif
        case (state_q)
            WAIT_LOCK: begin
                if (all_locked_d) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    // Only the channels still unlocked get reset; the mask is
                    // held in rst_out_q for the whole pulse.
                    state_d   = DCM_RST;
                    timer_d   = '0;
                    rst_out_d = CHAN_MASK & ~lock_sync_w;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DCM_RST: begin
                // Lock changes are ignored here: the pulse always runs full width.
                if (timer_q == RST_LAST) begin
                    state_d   = WAIT_LOCK;
                    timer_d   = '0;
                    rst_out_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STABLE: begin
                if (!all_locked_d) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                if (!all_locked_d) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
`ifdef DCM_LOCK_LOSS_COUNT_EN
                    loss_cnt_d = sat_inc(loss_cnt_q);
`endif
                end
            end
            default: begin
                state_d   = WAIT_LOCK;
                timer_d   = '0;
                rst_out_d = '0;
            end
        endcase
        // Rises one cycle after RUN entry, falls on the same edge RUN is left.
        sys_rst_n_d = (state_q == RUN) && (state_d == RUN);
    end

    // State and registered outputs; reset clears the DCM pulse asynchronously.
    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_LOCK;
            timer_q      <= '0;
            rst_out_q    <= '0;
            sys_rst_n_q  <= 1'b0;
            all_locked_q <= 1'b0;
`ifdef DCM_LOCK_LOSS_COUNT_EN
            loss_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rst_out_q    <= rst_out_d;
            sys_rst_n_q  <= sys_rst_n_d;
            all_locked_q <= all_locked_d;
`ifdef DCM_LOCK_LOSS_COUNT_EN
            loss_cnt_q   <= loss_cnt_d;
`endif
        end
    end

    assign bus.dcm_reset_out = rst_out_q;
    assign bus.sys_reset_n   = sys_rst_n_q;
    assign bus.all_locked    = all_locked_q;
    assign bus.seq_state     = state_q;
`ifdef DCM_LOCK_LOSS_COUNT_EN
    assign bus.lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// tb_dcm_reset_sequencer: directed scenarios plus randomized lock traffic,
// checked every cycle against a behavioural model of the sequencer rules.
// Lock-loss counter checks are active when DCM_LOCK_LOSS_COUNT_EN is defined.
module tb_dcm_reset_sequencer;

    localparam int         LT   = 20;
    localparam int         RC   = 4;
    localparam int         SC   = 8;
    localparam logic [2:0] MASK = 3'b111;

    logic       input_clk = 1'b0;
    logic       reset_n   = 1'b0;
    logic [2:0] din       = 3'b111;

    always #5 input_clk = ~input_clk;

    dcm_reset_sequencer_if bus_a ();
    dcm_reset_sequencer_if bus_b ();

    assign bus_a.dcm_locked_in = din;
    assign bus_b.dcm_locked_in = ~din;

    dcm_reset_sequencer #(
        .LOCK_TIMEOUT(LT), .DCM_RST_CYCLES(RC), .STABLE_CYCLES(SC), .CHAN_MASK(MASK)
    ) u_dut_a (
        .input_clk (input_clk),
        .reset_n   (reset_n),
        .bus       (bus_a)
    );

    // Second instance with every channel unmonitored.
    dcm_reset_sequencer #(
        .LOCK_TIMEOUT(LT), .DCM_RST_CYCLES(RC), .STABLE_CYCLES(SC), .CHAN_MASK(3'b000)
    ) u_dut_b (
        .input_clk (input_clk),
        .reset_n   (reset_n),
        .bus       (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for lock, 1 DCM reset pulse, 2 counting stable, 3 running
    int         m_phase = 0, m_waited = 0, m_left = 0, m_held = 0, m_cnt = 0, cyc = 0;
    logic [2:0] m_rst = 3'b000;
    logic       m_al = 1'b0, m_sysr = 1'b0;
    logic [2:0] seen1 = 3'b000, seen2 = 3'b000;   // lock inputs seen 1 and 2 edges ago

    task automatic model_clear();
        m_phase = 0; m_waited = 0; m_left = 0; m_held = 0; m_cnt = 0; cyc = 0;
        m_rst = 3'b000; m_al = 1'b0; m_sysr = 1'b0; seen1 = 3'b000; seen2 = 3'b000;
    endtask

    task automatic model_step(input logic [2:0] now_in);
        logic [2:0] lk;
        logic       ok;
        lk = seen2;                       // decisions use the lock value from two edges back
        ok = &(lk | ~MASK);
        cyc++;
        m_al = ok;
        case (m_phase)
            0: if (ok) begin
                   m_phase = 2; m_held = 0;
               end else begin
                   m_waited++;
                   if (m_waited == LT) begin
                       m_phase = 1; m_rst = MASK & ~lk; m_left = RC;
                   end
               end
            1: begin
                   m_left--;
                   if (m_left == 0) begin m_phase = 0; m_waited = 0; m_rst = 3'b000; end
               end
            2: if (!ok) begin
                   m_phase = 0; m_waited = 0;
               end else begin
                   m_held++;
                   if (m_held == SC) m_phase = 3;
               end
            default: if (!ok) begin
                   m_phase = 0; m_waited = 0; m_sysr = 1'b0;
                   if (m_cnt < 255) m_cnt++;
               end else begin
                   m_sysr = 1'b1;
               end
        endcase
        seen2 = seen1;
        seen1 = now_in;
    endtask

    initial begin
        forever begin
            @(posedge input_clk or negedge reset_n);
            if (!reset_n) model_clear();
            else          model_step(din);
        end
    end

    // ---------------- per-cycle comparison ----------------
    int first_al = 0, first_sys = 0;

    initial begin
        forever begin
            @(negedge input_clk);
            check("state",   32'(bus_a.seq_state),     32'(m_phase));
            check("dcm_rst", 32'(bus_a.dcm_reset_out), 32'(m_rst));
            check("sys_rst", 32'(bus_a.sys_reset_n),   32'(m_sysr));
            check("all_lk",  32'(bus_a.all_locked),    32'(m_al));
`ifdef DCM_LOCK_LOSS_COUNT_EN
            check("loss_cnt", 32'(bus_a.lock_loss_count), 32'(m_cnt));
`endif
            if (reset_n && bus_a.all_locked  && first_al  == 0) first_al  = cyc;
            if (reset_n && bus_a.sys_reset_n && first_sys == 0) first_sys = cyc;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_sys(input logic v, input int budget, input string tag);
        int k = 0;
        while (bus_a.sys_reset_n !== v && k < budget) begin
            @(negedge input_clk); k++;
        end
        if (k >= budget) check(tag, 32'(bus_a.sys_reset_n), 32'(v));
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget, input string tag,
                              output int waited);
        waited = 0;
        while (bus_a.seq_state !== tgt && waited < budget) begin
            @(negedge input_clk); waited++;
        end
        if (waited >= budget) check(tag, 32'(bus_a.seq_state), 32'(tgt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, w, g, k;
        logic [2:0] val;

        // Reset values
        din = 3'b111;
        repeat (3) @(negedge input_clk);
        check("rst_state",  32'(bus_a.seq_state),     32'd0);
        check("rst_dcmout", 32'(bus_a.dcm_reset_out), 32'd0);
        check("rst_sysrst", 32'(bus_a.sys_reset_n),   32'd0);
        check("rst_alllk",  32'(bus_a.all_locked),    32'd0);

        // All locked from release: all_locked at cycle 3, system reset released at 12
        reset_n = 1'b1;
        repeat (14) @(negedge input_clk);
        check("al_rise_cyc",  32'(first_al),  32'd3);
        check("sys_rise_cyc", 32'(first_sys), 32'd12);
        check("nomask_sys",   32'(bus_b.sys_reset_n), 32'd1);
        check("nomask_state", 32'(bus_b.seq_state),   32'd3);

        // One-cycle drop of bit0 in RUN
        din = 3'b110;
        @(negedge input_clk);
        din = 3'b111;
        lat = 1;
        while (bus_a.sys_reset_n !== 1'b0 && lat < 10) begin @(negedge input_clk); lat++; end
        check("loss_latency_le4", 32'(lat <= 4), 32'd1);
        wait_sys(1'b1, 30, "relock_timeout");
`ifdef DCM_LOCK_LOSS_COUNT_EN
        check("loss_cnt_one", 32'(bus_a.lock_loss_count), 32'd1);
`endif

        // Bit2 glitch in STABLE forces a full recount
        din = 3'b000;
        repeat (3) @(negedge input_clk);
        din = 3'b111;
        wait_state(2'd2, 10, "enter_stable", w);
        repeat (5) @(negedge input_clk);
        din = 3'b011;
        @(negedge input_clk);
        din = 3'b111;
        wait_state(2'd0, 6, "stable_abort", w);
        wait_state(2'd2, 10, "reenter_stable", w);
        wait_state(2'd3, 20, "stable_to_run", w);
        check("stable_len", 32'(w), 32'(SC));

        // Bit1 stuck low: repeated 4-cycle pulses on channel 1, 20 cycles apart
        din = 3'b101;
        k = 0;
        while (bus_a.dcm_reset_out === 3'b000 && k < 60) begin @(negedge input_clk); k++; end
        check("pulse1_value", 32'(bus_a.dcm_reset_out), 32'h2);
        w = 0;
        while (bus_a.dcm_reset_out !== 3'b000 && w < 20) begin w++; @(negedge input_clk); end
        check("pulse1_width", 32'(w), 32'(RC));
        g = 0;
        while (bus_a.dcm_reset_out === 3'b000 && g < 60) begin g++; @(negedge input_clk); end
        check("pulse_gap", 32'(g), 32'(LT));
        check("pulse2_value", 32'(bus_a.dcm_reset_out), 32'h2);
        din = 3'b000;   // lock lost mid-pulse must not shorten it
        w = 0;
        while (bus_a.dcm_reset_out !== 3'b000 && w < 20) begin w++; @(negedge input_clk); end
        check("pulse2_width", 32'(w), 32'(RC));
        din = 3'b111;

        // Randomized lock traffic
        for (int seg = 0; seg < 120; seg++) begin
            val = ($urandom_range(0, 9) < 7) ? 3'b111 : 3'($urandom_range(0, 7));
            k = $urandom_range(1, 40);
            repeat (k) begin @(negedge input_clk); din = val; end
        end
        din = 3'b111;
        wait_sys(1'b1, 60, "random_relock");
        check("nomask_still_run", 32'(bus_b.sys_reset_n), 32'd1);

        // 300 forced lock losses
        for (int i = 0; i < 300; i++) begin
            wait_sys(1'b1, 40, "loss_loop_up");
            din = 3'b110;
            @(negedge input_clk);
            din = 3'b111;
            wait_sys(1'b0, 10, "loss_loop_down");
        end
`ifdef DCM_LOCK_LOSS_COUNT_EN
        check("loss_cnt_sat", 32'(bus_a.lock_loss_count), 32'd255);
`endif

        // Asynchronous reset in the middle of a DCM reset pulse
        wait_sys(1'b1, 40, "pre_async_up");
        din = 3'b101;
        k = 0;
        while (bus_a.dcm_reset_out === 3'b000 && k < 60) begin @(negedge input_clk); k++; end
        check("async_pre_pulse", 32'(bus_a.dcm_reset_out), 32'h2);
        @(posedge input_clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_dcmout", 32'(bus_a.dcm_reset_out), 32'd0);
        check("async_sysrst", 32'(bus_a.sys_reset_n),   32'd0);
        check("async_alllk",  32'(bus_a.all_locked),    32'd0);
        check("async_state",  32'(bus_a.seq_state),     32'd0);
`ifdef DCM_LOCK_LOSS_COUNT_EN
        check("async_losscnt", 32'(bus_a.lock_loss_count), 32'd0);
`endif
        repeat (3) @(negedge input_clk);
        check("async_hold_dcmout", 32'(bus_a.dcm_reset_out), 32'd0);
        din = 3'b111;
        reset_n = 1'b1;
        wait_sys(1'b1, 30, "post_reset_up");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
